seq_detect_moore: RTL and testbench
===================================

Name: seq_detect_moore

Overview:
Parametrised, runtime-programmable serial pattern detector built as a Moore FSM. It generalises the fixed 8-state detector to any pattern length and supports overlap and non-overlap modes. The state is the length of the matched prefix (0..PAT_W), and the output is a pure function of that state. It sits between a serial bit source and downstream event logic, and carries an optional saturating hit counter.

Parameters:
PAT_W, 4, pattern length in bits (≥1); FSM has PAT_W+1 states.
RST_PAT, 4'b1011, pattern loaded at reset (width PAT_W).
CNT_W, 8, hit counter width (≥1).

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
x_vld  input  1  x is sampled this edge when 1
x  input  1  serial data bit
ovl  input  1  1 = overlapping matches, 0 = non-overlapping; sampled with each valid bit
cfg_load  input  1  one-cycle strobe: load cfg_pattern
cfg_pattern  input  PAT_W  new pattern; bit PAT_W-1 is the first bit of the sequence
y  output  1  Moore match flag: 1 while state == PAT_W
state_o  output  $clog2(PAT_W+1)  current matched-prefix length, for debug
hit_cnt  output  CNT_W  saturating match count (0 when feature compiled out)

Behaviour:
- Reset (reset=0, async):
  - pattern=RST_PAT, state=0, hist=0, fill=0, hit_cnt=0.
  - y=0 and state_o=0 immediately on reset assertion.
  - Normal operation resumes from the first rising edge after reset deasserts.
- Registers:
  - pattern[PAT_W].
  - hist[PAT_W]: shift left, new x into the LSB.
  - fill: count of bits since the last clear, saturating at PAT_W.
  - state.
- Valid sample (x_vld=1, cfg_load=0):
  - h' = {hist[PAT_W-2:0], x}; f' = min(fill+1, PAT_W).
  - Next state = largest k in 0..f' with h'[k-1:0] == pattern[PAT_W-1 -: k]; k=0 always matches.
  - This is prefix/suffix fallback (KMP-equivalent). Jumping straight to 0 on mismatch is incorrect.
- Non-overlap (ovl=0): when next state == PAT_W, fill is cleared to 0 instead of f'. The following samples therefore cannot reuse bits of the completed match.
- Overlap (ovl=1): fill is never cleared by a match.
- x_vld=0: state, hist and fill hold. y holds, so a match flag persists across idle cycles.
- Output latency: y rises in the cycle after the edge that sampled the final pattern bit. y falls after the next valid sample unless that sample completes another match. Two back-to-back matches keep y high.
- cfg_load=1:
  - pattern ← cfg_pattern; state, hist and fill ← 0; hit_cnt is unchanged.
  - cfg_load has priority over a coincident x_vld, and that bit is dropped.
  - y=0 from the next cycle.
- PAT_W=1: state ∈ {0,1}; y follows (x==pattern) on each valid sample.
- No X propagation: every state encoding is legal. Unused encodings above PAT_W (when PAT_W+1 is not a power of two) go to 0 on the next edge.

Optional Feature:
SEQ_DETECT_HITCNT_EN:
- Defined: hit_cnt increments by 1 on each edge where the next state == PAT_W from a valid sample. It saturates at 2^CNT_W-1 and is cleared only by reset.
- Undefined: no counter register; hit_cnt is tied to 0.

Decomposition:
- Package seq_detect_pkg holds:
  - state-width function clog2p1(PAT_W);
  - mode enum ovl_mode_t {OVL_OFF=0, OVL_ON=1};
  - default RST_PAT constant.
- Sub-module seq_detect_next: purely combinational, taking (pattern, h', f') to produce the next state via a descending-k loop. The top keeps all registers and the FSM update.

Test Plan:
- PAT_W=4, pattern 1011, ovl=1, stream 1,0,1,1,0,1,1 (x_vld=1 throughout) → y=1 after the 4th and 7th bits, state_o sequence 1,2,3,4,2,3,4, hit_cnt=2.
- Same stream with ovl=0 → y=1 only after the 4th bit; state_o after bits 5-7 = 0,1,1; hit_cnt=1.
- Pattern 1011, bits 1,0,1 then x_vld=0 for 5 cycles then 1 → state_o holds 3 through the gap, then 4; y stays 1 during a later idle gap after the match.
- Mid-sequence cfg_load with cfg_pattern=0110, coincident with x_vld=1 → dropped bit ignored, state_o=0; subsequent 0,1,1,0 → y=1.
- Async reset (reset=0) asserted mid-pattern between clock edges → y=0 and state_o=0 immediately; pattern reverts to 1011; hit_cnt=0.
- SEQ_DETECT_HITCNT_EN, CNT_W=2, ovl=1, pattern 1 with PAT_W=1, seven 1s → y held high, hit_cnt saturates at 3; macro undefined → hit_cnt stays 0.

Source files
------------

// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_pkg
//  Description : Shared types, constants and helper function for the
//                programmable Moore sequence detector.
//  Revision    : 1.0  initial release
// ============================================================================
package seq_detect_pkg;

    // Pattern loaded at reset when the default 4-bit configuration is used.
    localparam logic [3:0] C_RST_PAT_DEFAULT = 4'b1011;

    // Match mode: overlapping matches may reuse bits of a completed match.
    typedef enum logic {
        OVL_OFF = 1'b0,
        OVL_ON  = 1'b1
    } ovl_mode_t;

    // Width needed to hold the values 0..n (the matched-prefix length).
    function automatic int clog2p1(input int n);
        int w;
        w = 1;
        while ((1 << w) < (n + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detect_next.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_next
//  Description : Combinational next-state finder. Returns the longest
//                prefix of the pattern that is also a suffix of the updated
//                history, limited to the number of valid history bits.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_detect_next
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int ST_W  = clog2p1(PAT_W)
) (
    input  logic [PAT_W-1:0] i_pattern,   // bit PAT_W-1 is the first bit of the sequence
    input  logic [PAT_W-1:0] i_hist,      // updated history, newest bit in the LSB
    input  logic [ST_W-1:0]  i_fill,      // number of trustworthy history bits
    output logic [ST_W-1:0]  o_next
);

    logic w_found;
    logic w_match;

    // Search k from the longest candidate down; the first hit is the answer.
    // k = 0 always matches, which is the default.
    always_comb begin
        o_next  = '0;
        w_found = 1'b0;
        w_match = 1'b0;
        for (int k = PAT_W; k >= 1; k--) begin
            w_match = (k <= int'(i_fill));
            for (int j = 0; j < k; j++) begin
                // hist[k-1:0] lines up with pattern[PAT_W-1 -: k]
                if (i_hist[j] != i_pattern[PAT_W-k+j]) begin
                    w_match = 1'b0;
                end
            end
            if (w_match && !w_found) begin
                o_next  = ST_W'(k);
                w_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_detect_moore.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_moore
//  Description : Runtime-programmable serial pattern detector, Moore style.
//                The state is the matched-prefix length (0..PAT_W); y is
//                high while the full pattern is matched. Supports
//                overlapping and non-overlapping match modes.
//                Optional feature macro: SEQ_DETECT_HITCNT_EN enables a
//                saturating hit counter (hit_cnt is 0 otherwise).
//  Revision    : 1.0  initial release
// ============================================================================
module seq_detect_moore
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(C_RST_PAT_DEFAULT),
    parameter int               CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        reset,        // asynchronous, active low
    input  logic                        x_vld,
    input  logic                        x,
    input  logic                        ovl,
    input  logic                        cfg_load,
    input  logic [PAT_W-1:0]            cfg_pattern,
    output logic                        y,
    output logic [clog2p1(PAT_W)-1:0]   state_o,
    output logic [CNT_W-1:0]            hit_cnt
);

    localparam int              ST_W   = clog2p1(PAT_W);
    localparam logic [ST_W-1:0] C_FULL = ST_W'(PAT_W);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [PAT_W-1:0] r_pattern;
    logic [PAT_W-1:0] r_hist;
    logic [ST_W-1:0]  r_fill;
    logic [ST_W-1:0]  r_state;
    logic             r_y;

    // ------------------------------------------------------------------
    // Next-sample values
    // ------------------------------------------------------------------
    logic [PAT_W-1:0] w_hist_next;
    logic [ST_W-1:0]  w_fill_next;
    logic [ST_W-1:0]  w_next_state;
    logic             w_hit;
    logic             w_state_illegal;
    logic             w_clear_fill;
    logic             w_hist_msb_unused;

    // The oldest history bit is shifted out on every sample and never compared.
    assign w_hist_msb_unused = r_hist[PAT_W-1];

    generate
        if (PAT_W == 1) begin : g_hist_w1
            assign w_hist_next = x;
        end else begin : g_hist_wn
            assign w_hist_next = {r_hist[PAT_W-2:0], x};
        end
    endgenerate

    // Fill counts valid history bits and stops at the pattern length.
    assign w_fill_next = (r_fill >= C_FULL) ? C_FULL : (r_fill + ST_W'(1));

    seq_detect_next #(
        .PAT_W (PAT_W),
        .ST_W  (ST_W)
    ) u_next (
        .i_pattern (r_pattern),
        .i_hist    (w_hist_next),
        .i_fill    (w_fill_next),
        .o_next    (w_next_state)
    );

    assign w_hit           = (w_next_state == C_FULL);
    assign w_state_illegal = (r_state > C_FULL);
    // In non-overlap mode a completed match forgets all history so the next
    // match must be built from fresh bits only.
    assign w_clear_fill    = w_hit && (ovl_mode_t'(ovl) == OVL_OFF);

    // FSM update: configuration load wins over a coincident sample, idle
    // cycles hold everything (so y persists), stray encodings recover to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pattern <= RST_PAT;
            r_hist    <= '0;
            r_fill    <= '0;
            r_state   <= '0;
            r_y       <= 1'b0;
        end else if (cfg_load) begin
            r_pattern <= cfg_pattern;
            r_hist    <= '0;
            r_fill    <= '0;
            r_state   <= '0;
            r_y       <= 1'b0;
        end else if (x_vld) begin
            r_hist    <= w_hist_next;
            r_fill    <= w_clear_fill ? '0 : w_fill_next;
            r_state   <= w_next_state;
            r_y       <= w_hit;
        end else if (w_state_illegal) begin
            r_state   <= '0;
            r_y       <= 1'b0;
        end
    end

    assign y       = r_y;
    assign state_o = r_state;

    // ------------------------------------------------------------------
    // Optional saturating hit counter
    // ------------------------------------------------------------------
`ifdef SEQ_DETECT_HITCNT_EN
    logic [CNT_W-1:0] r_hit_cnt;

    // Count each sample that completes the pattern; stick at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hit_cnt <= '0;
        end else if (!cfg_load && x_vld && w_hit && (r_hit_cnt != {CNT_W{1'b1}})) begin
            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
        end
    end

    assign hit_cnt = r_hit_cnt;
`else
    assign hit_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_moore.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect_moore
//  Description : Self-checking bench for seq_detect_moore: directed vector
//                table, hand-written reset and single-bit-pattern sequences,
//                and randomized traffic against a stream-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_detect_moore;

    localparam int PW = 4;
`ifdef SEQ_DETECT_HITCNT_EN
    localparam bit HITCNT = 1'b1;
`else
    localparam bit HITCNT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       x_vld, x, ovl, cfg_load;
    logic [3:0] cfg_pattern;
    logic       y;
    logic [2:0] state_o;
    logic [7:0] hit_cnt;

    logic       x1_vld, x1, ovl1, cfg_load1;
    logic [0:0] cfg_pattern1;
    logic       y1;
    logic [0:0] state_o1;
    logic [1:0] hit_cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_detect_moore #(.PAT_W(4), .RST_PAT(4'b1011), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .x_vld(x_vld), .x(x), .ovl(ovl),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .y(y), .state_o(state_o), .hit_cnt(hit_cnt)
    );

    seq_detect_moore #(.PAT_W(1), .RST_PAT(1'b1), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .x_vld(x1_vld), .x(x1), .ovl(ovl1),
        .cfg_load(cfg_load1), .cfg_pattern(cfg_pattern1),
        .y(y1), .state_o(state_o1), .hit_cnt(hit_cnt1)
    );

    // ---------------- reference model (stream of bits since last clear) ----
    bit         m_stream[$];
    logic [3:0] m_pat;
    int         m_state;
    bit         m_y;
    int         m_cnt;

    task automatic m_reset();
        m_pat = 4'b1011;
        m_stream.delete();
        m_state = 0;
        m_y = 1'b0;
        m_cnt = 0;
    endtask

    task automatic m_step(input bit vld, input bit xb, input bit ov, input bit ld, input logic [3:0] pat);
        int best;
        bit ok;
        if (ld) begin
            m_pat = pat;
            m_stream.delete();
            m_state = 0;
            m_y = 1'b0;
        end else if (vld) begin
            m_stream.push_back(xb);
            if (m_stream.size() > PW) void'(m_stream.pop_front());
            best = 0;
            for (int k = 1; k <= m_stream.size(); k++) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++)
                    if (m_stream[m_stream.size() - k + i] != m_pat[PW-1-i]) ok = 1'b0;
                if (ok) best = k;
            end
            m_state = best;
            m_y = (best == PW);
            if (m_y) begin
                if (m_cnt < 255) m_cnt++;
                if (!ov) m_stream.delete();
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit vld, input bit xb, input bit ov, input bit ld, input logic [3:0] pat);
        x_vld = vld; x = xb; ovl = ov; cfg_load = ld; cfg_pattern = pat;
        @(posedge clk);
        #1;
        m_step(vld, xb, ov, ld, pat);
        x_vld = 1'b0; cfg_load = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " state"}, int'(state_o), m_state);
        chk({tag, " y"}, int'(y), int'(m_y));
        chk({tag, " hit_cnt"}, int'(hit_cnt), HITCNT ? m_cnt : 0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit         vld;
        bit         xb;
        bit         ov;
        bit         ld;
        logic [3:0] pat;
        int         exp_state;
        bit         exp_y;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit vld, bit xb, bit ov, bit ld, logic [3:0] pat, int st, bit yy);
        vec_t v;
        v.vld = vld; v.xb = xb; v.ov = ov; v.ld = ld; v.pat = pat;
        v.exp_state = st; v.exp_y = yy;
        tbl.push_back(v);
    endfunction

    initial begin
        bit s_bits[7];
        int s_ovl[7];
        int s_non[7];
        int c1;

        s_bits = '{1, 0, 1, 1, 0, 1, 1};
        s_ovl  = '{1, 2, 3, 4, 2, 3, 4};
        s_non  = '{1, 2, 3, 4, 0, 1, 1};
        // overlap stream
        for (int i = 0; i < 7; i++) add(1, s_bits[i], 1, 0, 4'b0000, s_ovl[i], s_ovl[i] == 4);
        add(0, 0, 1, 1, 4'b1011, 0, 0);
        // non-overlap stream
        for (int i = 0; i < 7; i++) add(1, s_bits[i], 0, 0, 4'b0000, s_non[i], s_non[i] == 4);
        add(0, 0, 1, 1, 4'b1011, 0, 0);
        // idle gap inside and after a match
        add(1, 1, 1, 0, 4'b0000, 1, 0);
        add(1, 0, 1, 0, 4'b0000, 2, 0);
        add(1, 1, 1, 0, 4'b0000, 3, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 1, 0, 4'b0000, 3, 0);
        add(1, 1, 1, 0, 4'b0000, 4, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 4'b0000, 4, 1);
        // load coincident with a valid bit, then new pattern 0110
        add(1, 1, 1, 1, 4'b0110, 0, 0);
        add(1, 0, 1, 0, 4'b0000, 1, 0);
        add(1, 1, 1, 0, 4'b0000, 2, 0);
        add(1, 1, 1, 0, 4'b0000, 3, 0);
        add(1, 0, 1, 0, 4'b0000, 4, 1);

        // ---------------- reset ----------------
        reset = 1'b0;
        x_vld = 0; x = 0; ovl = 0; cfg_load = 0; cfg_pattern = '0;
        x1_vld = 0; x1 = 0; ovl1 = 1; cfg_load1 = 0; cfg_pattern1 = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", int'(state_o), 0);
        chk("reset y", int'(y), 0);
        chk("reset hit_cnt", int'(hit_cnt), 0);
        @(negedge clk);
        reset = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].vld, tbl[i].xb, tbl[i].ov, tbl[i].ld, tbl[i].pat);
            chk($sformatf("tbl[%0d] state", i), int'(state_o), tbl[i].exp_state);
            chk($sformatf("tbl[%0d] y", i), int'(y), int'(tbl[i].exp_y));
            chk($sformatf("tbl[%0d] hit_cnt", i), int'(hit_cnt), HITCNT ? m_cnt : 0);
            if (i == 6) chk("hitcnt after overlap stream", int'(hit_cnt), HITCNT ? 2 : 0);
            if (i == 14) chk("hitcnt after non-overlap stream", int'(hit_cnt), HITCNT ? 3 : 0);
        end

        // ---------------- async reset mid-pattern ----------------
        drive(1, 0, 1, 0, 4'b0000); chk_model("pre-rst a");
        drive(1, 1, 1, 0, 4'b0000); chk_model("pre-rst b");
        #2 reset = 1'b0;
        #1;
        chk("async rst y", int'(y), 0);
        chk("async rst state", int'(state_o), 0);
        chk("async rst hit_cnt", int'(hit_cnt), 0);
        m_reset();
        @(negedge clk);
        reset = 1'b1;
        // pattern must be back to 1011
        drive(1, 1, 1, 0, 4'b0000); chk("post-rst s1", int'(state_o), 1);
        drive(1, 0, 1, 0, 4'b0000); chk("post-rst s2", int'(state_o), 2);
        drive(1, 1, 1, 0, 4'b0000); chk("post-rst s3", int'(state_o), 3);
        drive(1, 1, 1, 0, 4'b0000); chk("post-rst s4", int'(state_o), 4);
        chk("post-rst y", int'(y), 1);

        // ---------------- PAT_W=1, CNT_W=2 saturation ----------------
        c1 = 0;
        for (int i = 0; i < 7; i++) begin
            x1_vld = 1; x1 = 1; ovl1 = 1;
            @(posedge clk);
            #1;
            if (c1 < 3) c1++;
            chk($sformatf("w1 ones[%0d] y", i), int'(y1), 1);
            chk($sformatf("w1 ones[%0d] state", i), int'(state_o1), 1);
            chk($sformatf("w1 ones[%0d] hit_cnt", i), int'(hit_cnt1), HITCNT ? c1 : 0);
        end
        x1 = 0;
        @(posedge clk);
        #1;
        x1_vld = 0;
        chk("w1 zero y", int'(y1), 0);
        chk("w1 zero state", int'(state_o1), 0);
        chk("w1 zero hit_cnt", int'(hit_cnt1), HITCNT ? 3 : 0);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 75, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 99) < 3, 4'($urandom_range(0, 15)));
            chk_model($sformatf("rnd[%0d]", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
